// File: rtl/cam_gray_capture.sv
// Camera capture stage: frame-syncs on cam_vsync, assembles RGB565 byte pairs,
// converts each pixel to 8-bit luma and emits one frame-buffer write per pixel.
module cam_gray_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          cam_vsync,
  input  logic          href,
  input  logic [7:0]    pixel,
  output logic [7:0]    wr_data,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic          wren,
  output logic          frame_done,
  output logic          line_err
);

  typedef enum logic [1:0] {
    WAIT_VS_HIGH = 2'd0,
    WAIT_VS_LOW  = 2'd1,
    ACTIVE       = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            href_q, href_d;
  logic            vs_q, vs_d;
  logic            phase_q, phase_d;
  logic [7:0]      byte0_q, byte0_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [XW-1:0]   wr_x_q, wr_x_d;
  logic [YW-1:0]   wr_y_q, wr_y_d;
  logic            wren_q, wren_d;
  logic            frame_done_q, frame_done_d;
  logic            line_err_q, line_err_d;

  // Luma from byte0 (held) and the current byte1; 5/6-bit channels are
  // widened by replicating their MSBs so full-scale maps to 255.
  logic [7:0]  r8, g8, b8, gray;
  logic [16:0] sum;
  logic        x_in, y_in;

  always_comb begin
    r8   = {byte0_q[7:3], byte0_q[7:5]};
    g8   = {byte0_q[2:0], pixel[7:5], byte0_q[2:1]};
    b8   = {pixel[4:0], pixel[4:2]};
    sum  = 17'd77 * {9'd0, r8} + 17'd150 * {9'd0, g8} + 17'd29 * {9'd0, b8};
    gray = 8'(sum >> 8);
    x_in = int'(x_q) < H_PIXELS;
    y_in = int'(y_q) < V_LINES;
  end

  always_comb begin
    state_d      = state_q;
    href_d       = href;
    vs_d         = cam_vsync;
    phase_d      = phase_q;
    byte0_d      = byte0_q;
    x_d          = x_q;
    y_d          = y_q;
    wr_data_d    = wr_data_q;
    wr_x_d       = wr_x_q;
    wr_y_d       = wr_y_q;
    wren_d       = 1'b0;
    frame_done_d = 1'b0;
    line_err_d   = line_err_q;
    case (state_q)
      WAIT_VS_HIGH: if (cam_vsync) state_d = WAIT_VS_LOW;
      WAIT_VS_LOW: begin
        if (!cam_vsync) begin
          state_d    = ACTIVE;
          x_d        = '0;
          y_d        = '0;
          phase_d    = 1'b0;
          line_err_d = 1'b0;
        end
      end
      ACTIVE: begin
        // vsync overrides any byte traffic; a partial line is simply dropped
        if (cam_vsync) begin
          if (!vs_q) begin
            state_d      = WAIT_VS_LOW;
            frame_done_d = 1'b1;
          end
        end else if (href) begin
          if (!phase_q) begin
            byte0_d = pixel;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (y_in) begin
              if (x_in) begin
                wren_d    = 1'b1;
                wr_data_d = gray;
                wr_x_d    = x_q;
                wr_y_d    = y_q;
                x_d       = x_q + XW'(1);
              end else begin
                line_err_d = 1'b1;
              end
            end
          end
        end else if (href_q) begin
          if (phase_q) line_err_d = 1'b1;
          phase_d = 1'b0;
          x_d     = '0;
          if (y_in) y_d = y_q + YW'(1);
        end
      end
      default: state_d = WAIT_VS_HIGH;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= WAIT_VS_HIGH;
      href_q       <= 1'b0;
      vs_q         <= 1'b0;
      phase_q      <= 1'b0;
      byte0_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      wr_data_q    <= '0;
      wr_x_q       <= '0;
      wr_y_q       <= '0;
      wren_q       <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      href_q       <= href_d;
      vs_q         <= vs_d;
      phase_q      <= phase_d;
      byte0_q      <= byte0_d;
      x_q          <= x_d;
      y_q          <= y_d;
      wr_data_q    <= wr_data_d;
      wr_x_q       <= wr_x_d;
      wr_y_q       <= wr_y_d;
      wren_q       <= wren_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
    end
  end

  assign wr_data    = wr_data_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wren       = wren_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;

endmodule

// File: tb/tb_cam_gray_capture.sv
// Directed bench for cam_gray_capture with a 4x3 frame; writes are logged by a
// negedge monitor and compared against hand-computed coordinates and luma.
module tb_cam_gray_capture;
  localparam int H = 4;
  localparam int V = 3;

  logic       pclk = 1'b0;
  logic       reset, cam_vsync, href;
  logic [7:0] pixel, wr_data;
  logic [9:0] wr_x, wr_y;
  logic       wren, frame_done, line_err;

  int checks = 0;
  int errors = 0;
  int nfd    = 0;
  logic [27:0] wq[$];
  logic [7:0]  lbuf[0:15];

  cam_gray_capture #(.H_PIXELS(H), .V_LINES(V), .XW(10), .YW(10)) dut (
    .pclk(pclk), .reset(reset), .cam_vsync(cam_vsync), .href(href),
    .pixel(pixel), .wr_data(wr_data), .wr_x(wr_x), .wr_y(wr_y),
    .wren(wren), .frame_done(frame_done), .line_err(line_err)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (wren) wq.push_back({wr_y, wr_x, wr_data});
    if (frame_done) nfd++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] wget(input int i);
    return (i < wq.size()) ? wq[i] : '1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      href  = 1'b1;
      pixel = lbuf[i];
    end
    @(negedge pclk);
    href  = 1'b0;
    pixel = 8'h00;
    cyc(3);
  endtask

  task automatic zero_buf();
    for (int i = 0; i < 16; i++) lbuf[i] = 8'h00;
  endtask

  task automatic vs_pulse();
    @(negedge pclk); cam_vsync = 1'b1;
    cyc(3);
    @(negedge pclk); cam_vsync = 1'b0;
    cyc(2);
  endtask

  initial begin
    reset = 1'b1; cam_vsync = 1'b0; href = 1'b0; pixel = 8'h00;
    zero_buf();
    cyc(3);
    chk("rst_wren", wren, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_xy", {wr_x, wr_y}, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", line_err, 0);

    // blind start: vsync never seen high, nothing may be written
    @(negedge pclk); reset = 1'b0;
    for (int l = 0; l < 3; l++) send_line(8);
    chk("blind_writes", wq.size(), 0);
    chk("blind_fd", nfd, 0);

    // full frame, line 0 carries the colour vectors
    vs_pulse();
    wq.delete(); nfd = 0;
    lbuf[0] = 8'hF8; lbuf[1] = 8'h00; lbuf[2] = 8'h07; lbuf[3] = 8'hE0;
    lbuf[4] = 8'h00; lbuf[5] = 8'h1F; lbuf[6] = 8'hFF; lbuf[7] = 8'hFF;
    send_line(8);
    zero_buf();
    send_line(8);
    send_line(8);
    chk("frame_writes", wq.size(), 12);
    for (int i = 0; i < 12; i++)
      chk("frame_xy", wget(i) >> 8, {10'(i / 4), 10'(i % 4)});
    chk("luma_red", wget(0) & 8'hFF, 8'h4C);
    chk("luma_green", wget(1) & 8'hFF, 8'h95);
    chk("luma_blue", wget(2) & 8'hFF, 8'h1C);
    chk("luma_white", wget(3) & 8'hFF, 8'hFF);
    chk("luma_black", wget(4) & 8'hFF, 8'h00);
    @(negedge pclk); cam_vsync = 1'b1;
    cyc(4);
    chk("frame_fd", nfd, 1);
    chk("frame_err", line_err, 0);

    // odd-length line
    @(negedge pclk); cam_vsync = 1'b0;
    cyc(2);
    wq.delete(); nfd = 0;
    send_line(5);
    chk("odd_writes", wq.size(), 2);
    chk("odd_err", line_err, 1);
    send_line(8);
    chk("odd_next_xy", wget(2) >> 8, {10'd1, 10'd0});
    chk("odd_total", wq.size(), 6);
    @(negedge pclk); cam_vsync = 1'b1;
    cyc(3);
    chk("odd_err_held", line_err, 1);
    chk("odd_fd", nfd, 1);
    @(negedge pclk); cam_vsync = 1'b0;
    cyc(2);
    chk("err_clear", line_err, 0);

    // overlong line, then a line beyond V_LINES with the error already set
    wq.delete();
    send_line(10);
    chk("long_writes", wq.size(), 4);
    chk("long_err", line_err, 1);
    send_line(8);
    send_line(8);
    send_line(10);
    chk("extra_line_writes", wq.size(), 12);
    chk("extra_line_err1", line_err, 1);

    // line beyond V_LINES with the error clear
    vs_pulse();
    wq.delete();
    for (int l = 0; l < 3; l++) send_line(8);
    send_line(10);
    chk("vclip_writes", wq.size(), 12);
    chk("vclip_err0", line_err, 0);

    // reset mid-line
    vs_pulse();
    wq.delete(); nfd = 0;
    send_line(8);
    @(negedge pclk); href = 1'b1; pixel = 8'hF8;
    @(negedge pclk); pixel = 8'h00;
    @(negedge pclk); pixel = 8'h07;
    @(negedge pclk); pixel = 8'hE0; reset = 1'b1;
    chk("pre_rst_data", wr_data, 8'h4C);
    @(negedge pclk);
    chk("midrst_wren", wren, 0);
    chk("midrst_data", wr_data, 0);
    chk("midrst_xy", {wr_x, wr_y}, 0);
    chk("midrst_flags", {frame_done, line_err}, 0);
    wq.delete();
    href = 1'b0; reset = 1'b0;
    send_line(8);
    chk("post_rst_writes", wq.size(), 0);
    vs_pulse();
    send_line(8);
    chk("resync_writes", wq.size(), 4);
    chk("resync_fd", nfd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/cam_gray_capture.md
# cam_gray_capture

Camera-side capture stage in the `pclk` domain, sitting between the OV7670-style camera pins (`pixel`, `href`, `cam_vsync`) and the dual-clock frame buffer write port. It synchronises to frame boundaries and assembles RGB565 byte pairs into pixels. Each pixel is converted to 8-bit luma and emitted as one write (data, x, y, `wren`) into the buffer that the VGA path scans out. It also reports per-frame completion and malformed lines.

## Interface
Parameters:
- `H_PIXELS`, 640, pixels written per line; further pixels in a line are clipped.
- `V_LINES`, 480, lines written per frame; further lines are ignored.
- `XW`, 10, width of `wr_x`.
- `YW`, 10, width of `wr_y`.

Ports:
- `pclk`  in  1  camera pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `cam_vsync`  in  1  high during vertical blanking.
- `href`  in  1  high while line bytes are valid.
- `pixel`  in  8  camera data byte.
- `wr_data`  out  8  luma value.
- `wr_x`  out  XW  write column.
- `wr_y`  out  YW  write row.
- `wren`  out  1  one-cycle write strobe.
- `frame_done`  out  1  one-cycle pulse when a captured frame ends.
- `line_err`  out  1  sticky flag, set on an odd-length or overlong line and cleared on entry to ACTIVE.

## Operation
- Inputs are sampled on the rising edge of `pclk`. Registers `href_q` and `vs_q` hold the previous samples and reset to 0.
- FSM states:
  - WAIT_VS_HIGH (reset state): moves to WAIT_VS_LOW on the first edge with `cam_vsync`=1.
  - WAIT_VS_LOW: moves to ACTIVE on the first edge with `cam_vsync`=0. On that transition: x=0, y=0, phase=0, `line_err`=0.
  - ACTIVE: moves to WAIT_VS_LOW on a `cam_vsync` rising edge (`cam_vsync`=1, `vs_q`=0). On that transition `frame_done` pulses for one cycle.
- Writes occur only in ACTIVE. A frame already in progress when reset is released is never written.
- Byte assembly, in ACTIVE with `href`=1:
  - phase=0: latch `pixel` as byte0 = {R[4:0], G[5:3]}; phase becomes 1.
  - phase=1: the current `pixel` is byte1 = {G[2:0], B[4:0]}; the pixel is complete and phase becomes 0.
- Luma arithmetic, done on the phase=1 edge:
  - Expand to 8 bits: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - gray = (77·R8 + 150·G8 + 29·B8) >> 8, computed with a 17-bit unsigned sum. The result is always ≤255, so no saturation logic is needed.
- Write rules on a complete pixel:
  - If x < `H_PIXELS` and y < `V_LINES`: register `wren`=1, `wr_data`=gray, `wr_x`=x, `wr_y`=y, then x←x+1.
  - If x ≥ `H_PIXELS` (y < `V_LINES`): no write, `line_err`←1, x holds.
  - If y ≥ `V_LINES`: no write and no error.
- Line end, on an edge with `href`=0 and `href_q`=1:
  - If phase=1, the stray byte is dropped and `line_err`←1.
  - phase←0, x←0.
  - If y < `V_LINES`, y←y+1; otherwise y holds.
- `cam_vsync`=1 while `href`=1: `cam_vsync` wins and the partial line is discarded.
- Reset values: `wren`=0, `wr_data`=0, `wr_x`=0, `wr_y`=0, `frame_done`=0, `line_err`=0, FSM=WAIT_VS_HIGH, x=y=phase=0. Reset asserted mid-line aborts the line with no further writes.

## Timing
- Latency: `wren` and its data/address are valid in the cycle after the edge that samples byte1, i.e. one `pclk`.
- `wren` is high for exactly one cycle per pixel. With continuous `href` it pulses every second cycle.
- The last pixel of a line is registered before the `href` falling-edge processing, so it always carries the pre-increment y.
- `frame_done` is asserted in the cycle after the edge that detects the `cam_vsync` rising edge, for one cycle.
- `wr_data`, `wr_x`, `wr_y` hold their last values while `wren`=0.
- There is no backpressure: the buffer must accept one write every two cycles.

## Test plan
- Blind start: release reset with `cam_vsync`=0, drive 3 lines of 8 bytes with `href` → zero `wren` pulses and `frame_done` never asserted.
- Full frame (`H_PIXELS`=4, `V_LINES`=3): pulse `cam_vsync`, send 3 lines of 8 bytes, then raise `cam_vsync` → 12 writes at (0,0)…(3,0), (0,1)…(3,2); one `frame_done` pulse; `line_err`=0.
- Colour math, one byte pair per test:
  - 0xF8,0x00 → `wr_data`=0x4C
  - 0x07,0xE0 → 0x95
  - 0x00,0x1F → 0x1C
  - 0xFF,0xFF → 0xFF
  - 0x00,0x00 → 0x00
- Odd line: 5 bytes with `href`=1 → 2 writes, `line_err`=1, next line starts at x=0, y+1; `line_err` clears at the next frame start.
- Overflow: a 10-byte line with `H_PIXELS`=4 → 4 writes then `line_err`=1; a 4th line with `V_LINES`=3 → no writes and `line_err` unchanged.
- Reset mid-line after 3 bytes → next cycle all outputs 0, FSM in WAIT_VS_HIGH, no writes until a full `cam_vsync` high→low sequence.
